// File: rtl/car_sensor_fsm.sv
// car_sensor_fsm
//   Gate front end for the parking-lot occupancy path. The outer (A) and
//   inner (B) photo-sensor lines are synchronized and debounced. The
//   filtered pair is then followed through complete entry and exit
//   sequences. Each completed sequence produces a one-cycle inc or dec
//   pulse. Partial, reversed or illegal sequences never produce inc/dec.
//
// Ports
//   clk_i       system clock, all state on the rising edge
//   rst_ni      asynchronous reset, active low
//   sensor_a_i  raw outer sensor, 1 = beam blocked, asynchronous to clk_i
//   sensor_b_i  raw inner sensor, 1 = beam blocked, asynchronous to clk_i
//   inc_o       one-cycle pulse, complete entry detected
//   dec_o       one-cycle pulse, complete exit detected
//   err_o       one-cycle pulse, illegal sensor transition detected
//   busy_o      high while the FSM is not in IDLE (registered)
module car_sensor_fsm #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sensor_a_i,
  input  logic sensor_b_i,
  output logic inc_o,
  output logic dec_o,
  output logic err_o,
  output logic busy_o
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE - 1);

  typedef enum logic [2:0] {
    IDLE, EN1, EN2, EN3, EX1, EX2, EX3, ERR
  } state_e;

  logic          aMeta_q, aSync_q, bMeta_q, bSync_q;
  logic          aFilt_q, aFilt_d, bFilt_q, bFilt_d;
  logic [CW-1:0] aCnt_q, aCnt_d, bCnt_q, bCnt_d;
  logic [1:0]    pairPrev_q, pair;
  logic          changed, goErr;
  state_e        state_q, state_d;
  logic          inc_q, inc_d, dec_q, dec_d, err_q, err_d, busy_q;

  // Two-flop synchronizers for the asynchronous sensor lines.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aMeta_q <= 1'b0;
      aSync_q <= 1'b0;
      bMeta_q <= 1'b0;
      bSync_q <= 1'b0;
    end else begin
      aMeta_q <= sensor_a_i;
      aSync_q <= aMeta_q;
      bMeta_q <= sensor_b_i;
      bSync_q <= bMeta_q;
    end
  end

  // Debounce: a filtered bit only follows its synchronized input after the
  // input has disagreed with it for DEBOUNCE consecutive cycles. Any
  // agreement clears the count, so the counter never wraps.
  always_comb begin
    aFilt_d = aFilt_q;
    aCnt_d  = aCnt_q;
    if (aSync_q == aFilt_q) begin
      aCnt_d = '0;
    end else if (aCnt_q == CntLast) begin
      aFilt_d = aSync_q;
      aCnt_d  = '0;
    end else begin
      aCnt_d = aCnt_q + CW'(1);
    end

    bFilt_d = bFilt_q;
    bCnt_d  = bCnt_q;
    if (bSync_q == bFilt_q) begin
      bCnt_d = '0;
    end else if (bCnt_q == CntLast) begin
      bFilt_d = bSync_q;
      bCnt_d  = '0;
    end else begin
      bCnt_d = bCnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aFilt_q <= 1'b0;
      aCnt_q  <= '0;
      bFilt_q <= 1'b0;
      bCnt_q  <= '0;
    end else begin
      aFilt_q <= aFilt_d;
      aCnt_q  <= aCnt_d;
      bFilt_q <= bFilt_d;
      bCnt_q  <= bCnt_d;
    end
  end

  assign pair    = {aFilt_q, bFilt_q};
  assign changed = (pair != pairPrev_q);

  // Sequence tracker. Legal moves step one position along the entry or exit
  // path, in either direction. ERR is left as soon as both beams are clear.
  // This check is level-based, so entering ERR on a change to 00 still
  // returns to IDLE on the next cycle.
  always_comb begin
    state_d = state_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    err_d   = 1'b0;
    goErr   = 1'b0;
    if (state_q == ERR) begin
      if (pair == 2'b00) state_d = IDLE;
    end else if (changed) begin
      unique case (state_q)
        IDLE: begin
          if (pair == 2'b10)      state_d = EN1;
          else if (pair == 2'b01) state_d = EX1;
          else                    goErr   = 1'b1;
        end
        EN1: begin
          if (pair == 2'b11)      state_d = EN2;
          else if (pair == 2'b00) state_d = IDLE;
          else                    goErr   = 1'b1;
        end
        EN2: begin
          if (pair == 2'b01)      state_d = EN3;
          else if (pair == 2'b10) state_d = EN1;
          else                    goErr   = 1'b1;
        end
        EN3: begin
          if (pair == 2'b00) begin
            state_d = IDLE;
            inc_d   = 1'b1;
          end else if (pair == 2'b11) begin
            state_d = EN2;
          end else begin
            goErr = 1'b1;
          end
        end
        EX1: begin
          if (pair == 2'b11)      state_d = EX2;
          else if (pair == 2'b00) state_d = IDLE;
          else                    goErr   = 1'b1;
        end
        EX2: begin
          if (pair == 2'b10)      state_d = EX3;
          else if (pair == 2'b01) state_d = EX1;
          else                    goErr   = 1'b1;
        end
        EX3: begin
          if (pair == 2'b00) begin
            state_d = IDLE;
            dec_d   = 1'b1;
          end else if (pair == 2'b11) begin
            state_d = EX2;
          end else begin
            goErr = 1'b1;
          end
        end
        default: goErr = 1'b1;
      endcase
      if (goErr) begin
        state_d = ERR;
        err_d   = 1'b1;
      end
    end
  end

  // State and registered outputs. The pulses line up with the state update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pairPrev_q <= 2'b00;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pairPrev_q <= pair;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      err_q      <= err_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign inc_o  = inc_q;
  assign dec_o  = dec_q;
  assign err_o  = err_q;
  assign busy_o = busy_q;

endmodule
